// File: rtl/accum_cpu.sv
// Accumulator CPU: 3-cycle FETCH/DECODE/EXEC machine with single-step IDLE and HALT.
// Memory is external; reads are combinational on data_bus, writes are captured at the rising edge.
module accum_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              en,
  input  logic              step,
  input  logic              go,
  output logic              idle,
  output logic              halted,
  output logic [ADDR_W-1:0] adr_bus,
  output logic              rd_mem,
  output logic              wr_mem,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] acc_dbg,
  output logic              zf,
  output logic              cf
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IDLE   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_JMP = 3'b101,
    OP_JZ  = 3'b110,
    OP_HLT = 3'b111
  } op_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zf_q, zf_d;
  logic              cf_q, cf_d;

  logic              rd_req, wr_req;
  logic [ADDR_W-1:0] adr_req;
  logic              active;

  op_t               opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;

  assign opcode  = op_t'(ir_q[DATA_W-1 -: 3]);
  assign ir_addr = ir_q[ADDR_W-1:0];
  // One extra bit captures ADD carry-out and SUB borrow (borrow = 1 means acc < M).
  assign sum_w   = {1'b0, acc_q} + {1'b0, data_bus};
  assign diff_w  = {1'b0, acc_q} - {1'b0, data_bus};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    adr_req = pc_q;
    case (state_q)
      S_FETCH: begin
        rd_req  = 1'b1;
        ir_d    = data_bus;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        adr_req = ir_addr;
        state_d = step ? S_IDLE : S_FETCH;
        case (opcode)
          OP_LDA: begin
            rd_req = 1'b1;
            acc_d  = data_bus;
            zf_d   = (data_bus == '0);
            cf_d   = 1'b0;
          end
          OP_STA: wr_req = 1'b1;
          OP_ADD: begin
            rd_req = 1'b1;
            acc_d  = sum_w[DATA_W-1:0];
            zf_d   = (sum_w[DATA_W-1:0] == '0);
            cf_d   = sum_w[DATA_W];
          end
          OP_SUB: begin
            rd_req = 1'b1;
            acc_d  = diff_w[DATA_W-1:0];
            zf_d   = (diff_w[DATA_W-1:0] == '0);
            cf_d   = ~diff_w[DATA_W];
          end
          OP_AND: begin
            rd_req = 1'b1;
            acc_d  = acc_q & data_bus;
            zf_d   = ((acc_q & data_bus) == '0);
            cf_d   = 1'b0;
          end
          OP_JMP: pc_d = ir_addr;
          OP_JZ:  if (zf_q) pc_d = ir_addr;
          default: state_d = S_HALT;
        endcase
      end
      S_IDLE: begin
        if (go || !step) state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
    end
  end

  // Strobes are gated combinationally so they drop in the same cycle en falls or reset rises.
  assign active   = en & ~reset;
  assign rd_mem   = rd_req & active;
  assign wr_mem   = wr_req & active & ~rd_req;
  assign adr_bus  = reset ? '0 : adr_req;
  assign idle     = ~reset & (state_q == S_IDLE);
  assign halted   = ~reset & (state_q == S_HALT);
  assign data_bus = wr_mem ? acc_q : {DATA_W{1'bz}};
  assign acc_dbg  = acc_q;
  assign zf       = zf_q;
  assign cf       = cf_q;

endmodule

// File: tb/tb_accum_cpu.sv
// Bench for accum_cpu: directed programs plus random programs, checked against an
// instruction-level model of the machine (registers, flags and a 32-word memory image).
module tb_accum_cpu;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          en     = 1'b0;
  logic          step   = 1'b0;
  logic          go     = 1'b0;
  logic          idle, halted, rd_mem, wr_mem, zf, cf;
  logic [AW-1:0] adr_bus;
  logic [DW-1:0] acc_dbg;
  wire  [DW-1:0] data_bus;

  logic [DW-1:0] mem [DEPTH];
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_a  = '0;
  logic [DW-1:0] ld_d  = '0;

  logic [DW-1:0] img [DEPTH];
  int            m_mem [DEPTH];
  int            m_pc, m_acc;
  bit            m_zf, m_cf, m_halt;

  int n_chk  = 0;
  int n_pass = 0;

  accum_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .reset(reset), .en(en), .step(step), .go(go),
    .idle(idle), .halted(halted), .adr_bus(adr_bus), .rd_mem(rd_mem),
    .wr_mem(wr_mem), .data_bus(data_bus), .acc_dbg(acc_dbg), .zf(zf), .cf(cf)
  );

  always #5 clk_in = ~clk_in;

  assign data_bus = (rd_mem && !wr_mem) ? mem[adr_bus] : {DW{1'bz}};

  always @(posedge clk_in) begin
    if (ld_we) mem[ld_a] <= ld_d;
    else if (wr_mem) mem[adr_bus] <= data_bus;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Instruction-set model: executes the instruction at m_pc in one go.
  task automatic model_exec();
    int ins, op, a, m;
    ins  = m_mem[m_pc];
    op   = ins / 32;
    a    = ins % 32;
    m    = m_mem[a];
    m_pc = (m_pc + 1) % DEPTH;
    case (op)
      0: begin m_acc = m; m_cf = 0; m_zf = (m_acc == 0); end
      1: m_mem[a] = m_acc;
      2: begin m_cf = (m_acc + m) > 255; m_acc = (m_acc + m) % 256; m_zf = (m_acc == 0); end
      3: begin m_cf = (m_acc >= m); m_acc = (m_acc - m + 256) % 256; m_zf = (m_acc == 0); end
      4: begin m_acc = m_acc & m; m_cf = 0; m_zf = (m_acc == 0); end
      5: m_pc = a;
      6: if (m_zf) m_pc = a;
      default: m_halt = 1;
    endcase
  endtask

  task automatic clear_img();
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
  endtask

  task automatic reset_load(input bit en_rst);
    reset = 1'b1; en = en_rst; go = 1'b0; #1;
    check("rst_halted_now", halted, 0);
    check("rst_idle_now", idle, 0);
    check("rst_rd_now", rd_mem, 0);
    check("rst_wr_now", wr_mem, 0);
    check("rst_adr_now", adr_bus, 0);
    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1'b1; ld_a = AW'(i); ld_d = img[i];
      @(posedge clk_in); #1;
    end
    ld_we = 1'b0; #1;
    check("rst_rd", rd_mem, 0);
    check("rst_wr", wr_mem, 0);
    check("rst_acc", acc_dbg, 0);
    check("rst_zf", zf, 0);
    check("rst_cf", cf, 0);
    m_pc = 0; m_acc = 0; m_zf = 0; m_cf = 0; m_halt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = int'(img[i]);
    reset = 1'b0; en = 1'b1; #1;
  endtask

  task automatic adv(input bit stalls);
    if (stalls && $urandom_range(0, 2) == 0) begin
      en = 1'b0; go = 1'($urandom_range(0, 1)); #1;
      check("stall_rd", rd_mem, 0);
      check("stall_wr", wr_mem, 0);
      @(posedge clk_in); #1;
      en = 1'b1; go = 1'b0;
    end
    @(posedge clk_in); #1;
  endtask

  task automatic run_prog(input int max_instr, input bit use_step, input bit stalls);
    int ins, op, a;
    bit exp_rd, exp_wr;
    for (int i = 0; i < max_instr; i++) begin
      ins = m_mem[m_pc]; op = ins / 32; a = ins % 32;
      check("fetch_rd", rd_mem, 1);
      check("fetch_wr", wr_mem, 0);
      check("fetch_adr", adr_bus, m_pc);
      check("fetch_idle", idle, 0);
      adv(stalls);
      check("dec_rd", rd_mem, 0);
      check("dec_wr", wr_mem, 0);
      adv(stalls);
      exp_rd = (op == 0 || op == 2 || op == 3 || op == 4);
      exp_wr = (op == 1);
      check("exec_rd", rd_mem, exp_rd);
      check("exec_wr", wr_mem, exp_wr);
      if (exp_rd || exp_wr) check("exec_adr", adr_bus, a);
      if (exp_wr) check("sta_data", data_bus, m_acc);
      adv(stalls);
      model_exec();
      $display("instr word=%02h acc=%02h zf=%0d cf=%0d next_pc=%0d", ins, acc_dbg, zf, cf, m_pc);
      check("acc", acc_dbg, m_acc);
      check("zf", zf, m_zf);
      check("cf", cf, m_cf);
      check("halted", halted, m_halt);
      if (m_halt) begin
        go = 1'b1; @(posedge clk_in); #1; go = 1'b0;
        check("halt_go", halted, 1);
        check("halt_rd", rd_mem, 0);
        check("halt_wr", wr_mem, 0);
        return;
      end
      if (use_step) begin
        check("idle_set", idle, 1);
        check("idle_rd", rd_mem, 0);
        check("idle_wr", wr_mem, 0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_in); #1;
          check("idle_hold", idle, 1);
          check("idle_hold_rd", rd_mem, 0);
        end
        en = 1'b0; go = 1'b1; @(posedge clk_in); #1;
        en = 1'b1; go = 1'b0; #1;
        check("idle_go_en0", idle, 1);
        if ($urandom_range(0, 3) == 0) begin
          step = 1'b0; @(posedge clk_in); #1;
          check("idle_step_clr", idle, 0);
          step = 1'b1;
        end else begin
          go = 1'b1; @(posedge clk_in); #1; go = 1'b0;
          check("idle_go", idle, 0);
        end
      end
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) check("mem", mem[i], m_mem[i]);
  endtask

  initial begin
    // Sum two operands and store the result.
    clear_img();
    img[0] = 8'h0A; img[1] = 8'h4B; img[2] = 8'h2C; img[3] = 8'hE0;
    img[10] = 8'h05; img[11] = 8'h07;
    step = 1'b0;
    reset_load(1'b0);
    run_prog(10, 1'b0, 1'b0);
    check("p1_mem12", mem[12], 8'h0C);
    check("p1_acc", acc_dbg, 8'h0C);
    check("p1_zf", zf, 0);
    check("p1_cf", cf, 0);
    check("p1_halted", halted, 1);

    // Overflow to zero, then a taken JZ.
    clear_img();
    img[0] = 8'h10; img[1] = 8'h51; img[2] = 8'hD4; img[20] = 8'hE0;
    img[16] = 8'hFF; img[17] = 8'h01;
    reset_load(1'b1);
    run_prog(2, 1'b0, 1'b0);
    check("p2_acc", acc_dbg, 8'h00);
    check("p2_zf", zf, 1);
    check("p2_cf", cf, 1);
    run_prog(1, 1'b0, 1'b0);
    check("p2_jz_target", adr_bus, 20);
    run_prog(1, 1'b0, 1'b0);

    // Borrowing subtract, then an untaken JZ.
    clear_img();
    img[0] = 8'h10; img[1] = 8'h71; img[2] = 8'hD4; img[3] = 8'hE0;
    img[16] = 8'h02; img[17] = 8'h03;
    reset_load(1'b1);
    run_prog(2, 1'b0, 1'b0);
    check("p3_acc", acc_dbg, 8'hFF);
    check("p3_cf", cf, 0);
    check("p3_zf", zf, 0);
    run_prog(1, 1'b0, 1'b0);
    check("p3_jz_fall", adr_bus, 3);
    run_prog(1, 1'b0, 1'b0);

    // Single-step through three instructions.
    clear_img();
    img[0] = 8'h10; img[1] = 8'h51; img[2] = 8'h32; img[3] = 8'hE0;
    img[16] = 8'h10; img[17] = 8'h22;
    step = 1'b1;
    reset_load(1'b1);
    run_prog(4, 1'b1, 1'b0);
    check("p4_mem18", mem[18], 8'h32);
    step = 1'b0;

    // Jump to the top address; pc wraps to 0 afterwards.
    clear_img();
    img[0] = 8'hBF; img[31] = 8'h10; img[16] = 8'h5A;
    reset_load(1'b1);
    run_prog(2, 1'b0, 1'b0);
    check("p5_wrap_adr", adr_bus, 0);
    check("p5_wrap_rd", rd_mem, 1);
    check("p5_acc", acc_dbg, 8'h5A);

    // Reset landing in the EXEC cycle of a store.
    clear_img();
    img[0] = 8'h10; img[1] = 8'h2C; img[16] = 8'h33; img[12] = 8'h99;
    reset_load(1'b1);
    run_prog(1, 1'b0, 1'b0);
    check("p6_fetch_adr", adr_bus, 1);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    check("p6_exec_wr", wr_mem, 1);
    reset = 1'b1; #1;
    check("p6_rst_wr", wr_mem, 0);
    check("p6_rst_adr", adr_bus, 0);
    @(posedge clk_in); #1;
    reset = 1'b0; #1;
    check("p6_acc", acc_dbg, 0);
    check("p6_mem12", mem[12], 8'h99);
    check("p6_fetch0_adr", adr_bus, 0);
    check("p6_fetch0_rd", rd_mem, 1);

    // Random programs with random stepping and enable stalls.
    for (int p = 0; p < 14; p++) begin
      for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom_range(0, 255));
      step = 1'($urandom_range(0, 1));
      reset_load(1'($urandom_range(0, 1)));
      run_prog(30, step, 1'($urandom_range(0, 1)));
      check_mem();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
